// File: rtl/load_store_unit.sv
// Data-memory load/store stage: one word-aligned valid/ready bus access per request, byte strobes for stores,
// sign/zero-extended load return. Optional macro LSU_MISALIGN_TRAP_EN faults misaligned accesses without a bus cycle.
module load_store_unit #(
    parameter int XLEN      = 32,   // only 32 is supported (4 byte lanes)
    parameter int DMADDRLEN = 32    // must not exceed XLEN
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic                 i_is_store,
    input  logic [2:0]           i_funct3,
    input  logic [XLEN-1:0]      i_addr,
    input  logic [XLEN-1:0]      i_wdata,
    output logic                 o_mem_valid,
    input  logic                 i_mem_ready,
    output logic [DMADDRLEN-1:0] o_mem_addr,
    output logic                 o_mem_we,
    output logic [3:0]           o_mem_wstrb,
    output logic [XLEN-1:0]      o_mem_wdata,
    input  logic                 i_mem_rvalid,
    input  logic [XLEN-1:0]      i_mem_rdata,
    output logic                 o_done,
    output logic [XLEN-1:0]      o_rdata,
    output logic                 o_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [2:0]             funct3_q, funct3_d;
    logic [1:0]             lo_addr_q, lo_addr_d;
    logic [DMADDRLEN-1:0]   mem_addr_q, mem_addr_d;
    logic                   mem_we_q, mem_we_d;
    logic [3:0]             mem_wstrb_q, mem_wstrb_d;
    logic [XLEN-1:0]        mem_wdata_q, mem_wdata_d;
    logic [XLEN-1:0]        rdata_q, rdata_d;
    logic                   err_q, err_d;

    logic                   illegal;
    logic                   misalign;
    logic [3:0]             strb_n;
    logic [XLEN-1:0]        wdata_n;
    logic [XLEN-1:0]        rd_shifted;
    logic [7:0]             ld_byte;
    logic [15:0]            ld_half;
    logic [XLEN-1:0]        load_ext;

    assign illegal = i_is_store ? (i_funct3 > 3'b010)
                                : ((i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11));

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                      ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Store lane placement; loads leave strobes and write data at zero.
    always_comb begin
        strb_n  = 4'b0000;
        wdata_n = '0;
        if (i_is_store) begin
            case (i_funct3)
                3'b000: begin
                    strb_n  = 4'b0001 << i_addr[1:0];
                    wdata_n = {4{i_wdata[7:0]}};
                end
                3'b001: begin
                    strb_n  = i_addr[1] ? 4'b1100 : 4'b0011;
                    wdata_n = {2{i_wdata[15:0]}};
                end
                3'b010: begin
                    strb_n  = 4'b1111;
                    wdata_n = i_wdata;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_shifted = i_mem_rdata >> {lo_addr_q, 3'b000};
        ld_byte    = rd_shifted[7:0];
        ld_half    = lo_addr_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100:  load_ext = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001:  load_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b101:  load_ext = {{(XLEN-16){1'b0}}, ld_half};
            default: load_ext = i_mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        funct3_d    = funct3_q;
        lo_addr_d   = lo_addr_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    funct3_d  = i_funct3;
                    lo_addr_d = i_addr[1:0];
                    if (illegal || misalign) begin
                        state_d = S_DONE;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = S_REQ;
                        mem_addr_d  = {i_addr[DMADDRLEN-1:2], 2'b00};
                        mem_we_d    = i_is_store;
                        mem_wstrb_d = strb_n;
                        mem_wdata_d = wdata_n;
                    end
                end
            end
            S_REQ: begin
                if (i_mem_ready) begin
                    if (mem_we_q) begin
                        state_d = S_DONE;
                        rdata_d = '0;
                        err_d   = 1'b0;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (i_mem_rvalid) begin
                    state_d = S_DONE;
                    rdata_d = load_ext;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            funct3_q    <= 3'b000;
            lo_addr_q   <= 2'b00;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wstrb_q <= 4'b0000;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            funct3_q    <= funct3_d;
            lo_addr_q   <= lo_addr_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign o_req_ready = (state_q == S_IDLE);
    assign o_mem_valid = (state_q == S_REQ);
    assign o_done      = (state_q == S_DONE);
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_wstrb = mem_wstrb_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_rdata     = rdata_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses push expected bus/completion records,
// a negedge monitor pops and compares them as the DUT presents handshakes and done pulses.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_req_valid, i_is_store, i_mem_ready, i_mem_rvalid;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr, i_wdata, i_mem_rdata;
    logic        o_req_ready, o_mem_valid, o_mem_we, o_done, o_err;
    logic [31:0] o_mem_addr, o_mem_wdata, o_rdata;
    logic [3:0]  o_mem_wstrb;

    load_store_unit #(.XLEN(32), .DMADDRLEN(32)) dut (
        .clk(clk), .rstn(rstn),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_is_store(i_is_store), .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr),
        .o_mem_we(o_mem_we), .o_mem_wstrb(o_mem_wstrb), .o_mem_wdata(o_mem_wdata),
        .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
        .o_done(o_done), .o_rdata(o_rdata), .o_err(o_err)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] addr; logic we; logic [3:0] strb; logic [31:0] wdata;} bus_t;
    typedef struct {logic [31:0] rdata; logic err;} done_t;

    bus_t  bus_q[$];
    done_t done_q[$];
    int    checks   = 0;
    int    failures = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction

    // Monitor: bus handshakes, stall stability and completion records.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr, prev_wdata;
    logic [3:0]  prev_strb;
    always @(negedge clk) begin
        bus_t  b;
        done_t d;
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (o_mem_valid && prev_stall) begin
                chk("stall_addr", o_mem_addr, prev_addr);
                chk("stall_strb", {28'd0, o_mem_wstrb}, {28'd0, prev_strb});
                chk("stall_wdata", o_mem_wdata, prev_wdata);
                chk("stall_req_ready", {31'd0, o_req_ready}, 32'd0);
                chk("stall_done", {31'd0, o_done}, 32'd0);
            end
            if (o_mem_valid && i_mem_ready) begin
                if (bus_q.size() == 0) begin
                    chk("bus_expected", 32'(bus_q.size()), 32'd1);
                end else begin
                    b = bus_q.pop_front();
                    chk("bus_addr", o_mem_addr, b.addr);
                    chk("bus_we", {31'd0, o_mem_we}, {31'd0, b.we});
                    if (b.we) begin
                        chk("bus_wstrb", {28'd0, o_mem_wstrb}, {28'd0, b.strb});
                        chk("bus_wdata", o_mem_wdata, b.wdata);
                    end
                end
            end
            prev_stall = o_mem_valid && !i_mem_ready;
            prev_addr  = o_mem_addr;
            prev_strb  = o_mem_wstrb;
            prev_wdata = o_mem_wdata;
            if (o_done) begin
                if (done_q.size() == 0) begin
                    chk("done_expected", 32'(done_q.size()), 32'd1);
                end else begin
                    d = done_q.pop_front();
                    chk("done_rdata", o_rdata, d.rdata);
                    chk("done_err", {31'd0, o_err}, {31'd0, d.err});
                end
            end
        end
    end

    task automatic access(input string name, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int rdy, input int rv, input logic [31:0] rd,
                          input logic exp_bus, input logic [31:0] e_addr, input logic [3:0] e_strb,
                          input logic [31:0] e_wdata, input logic [31:0] e_rdata, input logic e_err);
        int   lat;
        int   done_k;
        logic saw_valid;
        lat       = !exp_bus ? 1 : (st ? 2 + rdy : 3 + rdy + rv);
        done_k    = -1;
        saw_valid = 1'b0;
        if (exp_bus) bus_q.push_back('{e_addr, st, e_strb, e_wdata});
        done_q.push_back('{e_rdata, e_err});
        @(negedge clk);
        chk({name, "_req_ready"}, {31'd0, o_req_ready}, 32'd1);
        @(posedge clk); #1;
        i_req_valid = 1'b1; i_is_store = st; i_funct3 = f3; i_addr = a; i_wdata = wd;
        @(posedge clk); #1;
        i_req_valid = 1'b0; i_wdata = 32'h0; i_addr = 32'h0;
        for (int k = 1; k <= 60; k++) begin
            i_mem_ready  = exp_bus && (k == 1 + rdy);
            i_mem_rvalid = exp_bus && !st && ((k == 2 + rdy + rv) || (k <= rdy));
            i_mem_rdata  = (k == 2 + rdy + rv) ? rd : 32'hBAD0_BAD0;
            @(negedge clk);
            if (o_mem_valid) saw_valid = 1'b1;
            if (o_done) begin
                done_k = k;
                break;
            end
            @(posedge clk); #1;
        end
        i_mem_ready = 1'b0; i_mem_rvalid = 1'b0;
        chk({name, "_latency"}, 32'(done_k), 32'(lat));
        if (!exp_bus) chk({name, "_no_bus"}, {31'd0, saw_valid}, 32'd0);
        @(negedge clk);
        chk({name, "_done_one_cycle"}, {31'd0, o_done}, 32'd0);
    endtask

    initial begin
        rstn = 1'b0;
        i_req_valid = 1'b0; i_is_store = 1'b0; i_funct3 = 3'b000; i_addr = 32'h0; i_wdata = 32'h0;
        i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, o_req_ready}, 32'd1);
        chk("rst_mem_valid", {31'd0, o_mem_valid}, 32'd0);
        chk("rst_mem_we", {31'd0, o_mem_we}, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_err", {31'd0, o_err}, 32'd0);
        chk("rst_rdata", o_rdata, 32'd0);
        chk("rst_mem_addr", o_mem_addr, 32'd0);
        chk("rst_wstrb", {28'd0, o_mem_wstrb}, 32'd0);
        chk("rst_wdata", o_mem_wdata, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        //     name    st  f3      addr          wdata         rdy rv rdata         bus  e_addr        strb     e_wdata       e_rdata       err
        access("sw",   1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 0, 0, 32'h0,         1, 32'h0000_0104, 4'b1111, 32'hDEAD_BEEF, 32'h0,         0);
        access("sb",   1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 0, 0, 32'h0,         1, 32'h0000_0200, 4'b1000, 32'hA5A5_A5A5, 32'h0,         0);
        access("lb",   0, 3'b000, 32'h0000_0302, 32'h0,         0, 1, 32'h1280_3456, 1, 32'h0000_0300, 4'b0000, 32'h0,         32'hFFFF_FF80, 0);
        access("lbu",  0, 3'b100, 32'h0000_0302, 32'h0,         0, 1, 32'h1280_3456, 1, 32'h0000_0300, 4'b0000, 32'h0,         32'h0000_0080, 0);
        access("lb1",  0, 3'b000, 32'h0000_0301, 32'h0,         0, 0, 32'h1280_3456, 1, 32'h0000_0300, 4'b0000, 32'h0,         32'h0000_0034, 0);
        access("lb3",  0, 3'b000, 32'h0000_0303, 32'h0,         0, 0, 32'h1280_3456, 1, 32'h0000_0300, 4'b0000, 32'h0,         32'h0000_0012, 0);
        access("lh",   0, 3'b001, 32'h0000_0402, 32'h0,         0, 0, 32'h8001_7FFF, 1, 32'h0000_0400, 4'b0000, 32'h0,         32'hFFFF_8001, 0);
        access("lhu",  0, 3'b101, 32'h0000_0402, 32'h0,         0, 0, 32'h8001_7FFF, 1, 32'h0000_0400, 4'b0000, 32'h0,         32'h0000_8001, 0);
        access("lhu0", 0, 3'b101, 32'h0000_0400, 32'h0,         0, 0, 32'h8001_7FFF, 1, 32'h0000_0400, 4'b0000, 32'h0,         32'h0000_7FFF, 0);
        access("lh0",  0, 3'b001, 32'h0000_0000, 32'h0,         0, 0, 32'hF0F0_8765, 1, 32'h0000_0000, 4'b0000, 32'h0,         32'hFFFF_8765, 0);
        access("sh_stall", 1, 3'b001, 32'h0000_0012, 32'h1234_ABCD, 5, 0, 32'h0,     1, 32'h0000_0010, 4'b1100, 32'hABCD_ABCD, 32'h0,         0);
        access("lw_stall", 0, 3'b010, 32'h0000_0600, 32'h0,     2, 2, 32'hCAFE_F00D, 1, 32'h0000_0600, 4'b0000, 32'h0,         32'hCAFE_F00D, 0);
        access("ill_ld", 0, 3'b011, 32'h0000_0700, 32'h0,       0, 0, 32'h0,         0, 32'h0,         4'b0000, 32'h0,         32'h0,         1);
        access("ill_st", 1, 3'b100, 32'h0000_0700, 32'h1111_2222, 0, 0, 32'h0,       0, 32'h0,         4'b0000, 32'h0,         32'h0,         1);
        access("sb0",  1, 3'b000, 32'h0000_0800, 32'h0000_1234, 0, 0, 32'h0,         1, 32'h0000_0800, 4'b0001, 32'h3434_3434, 32'h0,         0);
`ifdef LSU_MISALIGN_TRAP_EN
        access("lw_mis", 0, 3'b010, 32'h0000_0502, 32'h0,       0, 0, 32'h1122_3344, 0, 32'h0,         4'b0000, 32'h0,         32'h0,         1);
        access("sh_mis", 1, 3'b001, 32'h0000_0011, 32'h0000_BEEF, 0, 0, 32'h0,       0, 32'h0,         4'b0000, 32'h0,         32'h0,         1);
`else
        access("lw_mis", 0, 3'b010, 32'h0000_0502, 32'h0,       0, 0, 32'h1122_3344, 1, 32'h0000_0500, 4'b0000, 32'h0,         32'h1122_3344, 0);
        access("sh_mis", 1, 3'b001, 32'h0000_0011, 32'h0000_BEEF, 0, 0, 32'h0,       1, 32'h0000_0010, 4'b0011, 32'hBEEF_BEEF, 32'h0,         0);
`endif

        // Reset while the unit waits for read data: no completion may follow.
        bus_q.push_back('{32'h0000_0700, 1'b0, 4'b0000, 32'h0});
        @(posedge clk); #1;
        i_req_valid = 1'b1; i_is_store = 1'b0; i_funct3 = 3'b010; i_addr = 32'h0000_0700;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        i_mem_ready = 1'b1;
        @(posedge clk); #1;
        i_mem_ready = 1'b0;
        rstn = 1'b0;
        #1;
        chk("wait_rst_mem_valid", {31'd0, o_mem_valid}, 32'd0);
        chk("wait_rst_done", {31'd0, o_done}, 32'd0);
        chk("wait_rst_req_ready", {31'd0, o_req_ready}, 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'h5555_AAAA;
        repeat (4) @(posedge clk);
        #1;
        i_mem_rvalid = 1'b0;
        chk("post_rst_req_ready", {31'd0, o_req_ready}, 32'd1);

        access("sw_after", 1, 3'b010, 32'h0000_0900, 32'h0BAD_F00D, 1, 0, 32'h0,   1, 32'h0000_0900, 4'b1111, 32'h0BAD_F00D, 32'h0,         0);

        repeat (3) @(negedge clk);
        chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        chk("done_queue_drained", 32'(done_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
